systolic_pe_acc: RTL and testbench

Next-generation systolic processing element for the Q-projection array. Adds per-operand valid tagging, a tile "last" marker that drains and restarts the accumulator with no bubble, and a global stall. Also adds a registered multiplier stage and selectable signed/unsigned, saturating/wrapping arithmetic. Tiles into the same 2-D mesh: a/valid/last flow left to right, b/valid flow top to bottom.

---
 rtl/pe_pkg.sv | 58 +++++
 rtl/pe_acc_stage.sv | 74 +++++++
 rtl/systolic_pe_acc.sv | 88 ++++++++
 tb/tb_systolic_pe_acc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and accumulator arithmetic helpers for the systolic PE family.
// Widths are passed at call time so one package serves every parameterisation.
package pe_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned MAX_W  = 64;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [MAX_W-1:0]  wide_t;

  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } sat_res_t;

  function automatic wide_t lsb_mask(input int unsigned w);
    return (w >= MAX_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
  endfunction

  function automatic wide_t acc_max(input int unsigned w, input logic sgn);
    return sgn ? lsb_mask(w - 1) : lsb_mask(w);
  endfunction

  // Signed minimum is returned fully sign-extended; callers keep the low w bits.
  function automatic wide_t acc_min(input int unsigned w, input logic sgn);
    return sgn ? ~lsb_mask(w - 1) : '0;
  endfunction

  function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                       input int unsigned w, input logic sgn,
                                       input logic sat);
    wide_t          m;
    logic [MAX_W:0] s;
    wide_t          r;
    wide_t          top;
    logic           sa, sb, sr, carry;
    sat_res_t       o;
    m     = lsb_mask(w);
    top   = wide_t'(1) << (w - 1);
    s     = {1'b0, a & m} + {1'b0, b & m};
    r     = s[MAX_W-1:0] & m;
    sa    = (a & top) != '0;
    sb    = (b & top) != '0;
    sr    = (r & top) != '0;
    carry = s[MAX_W] | ((s[MAX_W-1:0] & ~m) != '0);
    if (sgn) begin
      o.ovf = (sa == sb) && (sr != sa);
      o.sum = (sat && o.ovf) ? (sa ? acc_min(w, sgn) : acc_max(w, sgn)) : r;
    end else begin
      o.ovf = carry;
      o.sum = (sat && o.ovf) ? acc_max(w, sgn) : r;
    end
    return o;
  endfunction

endpackage

// File: rtl/pe_acc_stage.sv
// Stage 2 of the PE: accumulate with optional saturation, drain on tile last,
// and hold the completed result until the next completion.
module pe_acc_stage
  import pe_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned PROD_WIDTH = 16,
  parameter int unsigned SIGNED     = 1,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  input  logic                  prod_v_i,
  input  logic                  prod_last_i,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  output logic                  res_ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d, prod_ext;
  logic                 ovf_q, ovf_d, res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;
  wide_t                acc_w, prod_w;
  sat_res_t             add;

  always_comb begin
    prod_ext    = (SIGNED != 0) ? ACC_WIDTH'($signed(prod_i)) : ACC_WIDTH'(prod_i);
    acc_w       = (SIGNED != 0) ? wide_t'($signed(acc_q))    : wide_t'(acc_q);
    prod_w      = (SIGNED != 0) ? wide_t'($signed(prod_ext)) : wide_t'(prod_ext);
    add         = sat_add(acc_w, prod_w, ACC_WIDTH, SIGNED != 0, SATURATE != 0);
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = 1'b0;
    if (en_i && prod_v_i) begin
      // Drain and restart in the same edge so the next tile needs no bubble.
      if (prod_last_i) begin
        res_d       = add.sum[ACC_WIDTH-1:0];
        res_ovf_d   = ovf_q | add.ovf;
        res_valid_d = 1'b1;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = add.sum[ACC_WIDTH-1:0];
        ovf_d = ovf_q | add.ovf;
      end
    end else if (!en_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign res_ovf_o   = res_ovf_q;

endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic MAC processing element: operand forwarding, registered product,
// and a tile-draining accumulator with global stall.
module systolic_pe_acc
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SIGNED     = 1,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic                  in_a_valid,
  input  logic                  in_a_last,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_b_valid,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic                  out_a_valid,
  output logic                  out_a_last,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_b_valid,
  output logic [ACC_WIDTH-1:0]  res,
  output logic                  res_valid,
  output logic                  res_ovf
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] out_a_q, out_b_q;
  logic                  out_a_valid_q, out_a_last_q, out_b_valid_q;
  logic [PW-1:0]         a_ext, b_ext, prod_d, prod_q;
  logic                  prod_v_q, prod_last_q;

  // Low 2N bits of the product of N-to-2N extended operands are exact in both modes.
  always_comb begin
    a_ext  = (SIGNED != 0) ? {{DATA_WIDTH{in_a[DATA_WIDTH-1]}}, in_a} : {{DATA_WIDTH{1'b0}}, in_a};
    b_ext  = (SIGNED != 0) ? {{DATA_WIDTH{in_b[DATA_WIDTH-1]}}, in_b} : {{DATA_WIDTH{1'b0}}, in_b};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_q       <= '0;
      out_a_valid_q <= 1'b0;
      out_a_last_q  <= 1'b0;
      out_b_q       <= '0;
      out_b_valid_q <= 1'b0;
      prod_q        <= '0;
      prod_v_q      <= 1'b0;
      prod_last_q   <= 1'b0;
    end else if (en) begin
      out_a_q       <= in_a;
      out_a_valid_q <= in_a_valid;
      out_a_last_q  <= in_a_last;
      out_b_q       <= in_b;
      out_b_valid_q <= in_b_valid;
      prod_q        <= prod_d;
      prod_v_q      <= in_a_valid & in_b_valid;
      prod_last_q   <= in_a_valid & in_b_valid & in_a_last;
    end
  end

  assign out_a       = out_a_q;
  assign out_a_valid = out_a_valid_q;
  assign out_a_last  = out_a_last_q;
  assign out_b       = out_b_q;
  assign out_b_valid = out_b_valid_q;

  pe_acc_stage #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PROD_WIDTH (PW),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_acc (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .prod_i      (prod_q),
    .prod_v_i    (prod_v_q),
    .prod_last_i (prod_last_q),
    .res_o       (res),
    .res_valid_o (res_valid),
    .res_ovf_o   (res_ovf)
  );

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Directed bench for systolic_pe_acc: table-driven main flow on the default
// configuration plus hand sequences for saturation, unsigned, stall and reset.
module tb_systolic_pe_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_a_valid = 1'b0, in_a_last = 1'b0, in_b_valid = 1'b0;

  logic [7:0]  out_a, out_b;
  logic        out_a_valid, out_a_last, out_b_valid;
  logic [31:0] res;
  logic        res_valid, res_ovf;

  logic [7:0]  s_oa, s_ob, w_oa, w_ob, u_oa, u_ob;
  logic        s_oav, s_oal, s_obv, w_oav, w_oal, w_obv, u_oav, u_oal, u_obv;
  logic [15:0] s_res, w_res;
  logic [31:0] u_res;
  logic        s_rv, s_ovf, w_rv, w_ovf, u_rv, u_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  systolic_pe_acc u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
    .in_b(in_b), .in_b_valid(in_b_valid),
    .out_a(out_a), .out_a_valid(out_a_valid), .out_a_last(out_a_last),
    .out_b(out_b), .out_b_valid(out_b_valid),
    .res(res), .res_valid(res_valid), .res_ovf(res_ovf)
  );

  systolic_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_sat16 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
    .in_b(in_b), .in_b_valid(in_b_valid),
    .out_a(s_oa), .out_a_valid(s_oav), .out_a_last(s_oal),
    .out_b(s_ob), .out_b_valid(s_obv),
    .res(s_res), .res_valid(s_rv), .res_ovf(s_ovf)
  );

  systolic_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) u_wrap16 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
    .in_b(in_b), .in_b_valid(in_b_valid),
    .out_a(w_oa), .out_a_valid(w_oav), .out_a_last(w_oal),
    .out_b(w_ob), .out_b_valid(w_obv),
    .res(w_res), .res_valid(w_rv), .res_ovf(w_ovf)
  );

  systolic_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0), .SATURATE(1)) u_uns (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
    .in_b(in_b), .in_b_valid(in_b_valid),
    .out_a(u_oa), .out_a_valid(u_oav), .out_a_last(u_oal),
    .out_b(u_ob), .out_b_valid(u_obv),
    .res(u_res), .res_valid(u_rv), .res_ovf(u_ovf)
  );

  typedef struct {
    logic [7:0]  a;
    logic        av;
    logic        al;
    logic [7:0]  b;
    logic        bv;
    logic        rv;
    logic [31:0] r;
    logic        ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic av, input logic al,
                       input logic [7:0] b, input logic bv);
    in_a = a; in_a_valid = av; in_a_last = al; in_b = b; in_b_valid = bv;
  endtask

  task automatic do_reset();
    drive(8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'd3,   1, 0, 8'd5, 1, 0, 32'd0,  0};
    tbl[1]  = '{8'd4,   1, 0, 8'd5, 1, 0, 32'd0,  0};
    tbl[2]  = '{8'hFE,  1, 1, 8'd5, 1, 0, 32'd0,  0};
    tbl[3]  = '{8'd0,   0, 0, 8'd0, 0, 1, 32'd25, 0};
    tbl[4]  = '{8'd2,   1, 0, 8'd3, 1, 0, 32'd25, 0};
    tbl[5]  = '{8'd2,   1, 1, 8'd3, 1, 0, 32'd25, 0};
    tbl[6]  = '{8'd1,   1, 1, 8'd7, 1, 1, 32'd12, 0};
    tbl[7]  = '{8'd0,   0, 0, 8'd0, 0, 1, 32'd7,  0};
    tbl[8]  = '{8'd0,   0, 0, 8'd0, 0, 0, 32'd7,  0};
    tbl[9]  = '{8'd9,   1, 1, 8'd0, 0, 0, 32'd7,  0};
    tbl[10] = '{8'd2,   1, 1, 8'd3, 1, 0, 32'd7,  0};
    tbl[11] = '{8'd0,   0, 0, 8'd0, 0, 1, 32'd6,  0};
    tbl[12] = '{8'd0,   0, 0, 8'd0, 0, 0, 32'd6,  0};
    tbl[13] = '{8'hFD,  1, 1, 8'd4, 1, 0, 32'd6,  0};
    tbl[14] = '{8'd0,   0, 0, 8'd0, 0, 1, 32'hFFFF_FFF4, 0};
    tbl[15] = '{8'd0,   0, 0, 8'd0, 0, 0, 32'hFFFF_FFF4, 0};

    // Reset state
    drive(8'hA5, 1'b1, 1'b1, 8'h5A, 1'b1);
    tick();
    tick();
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_out_a_last", 64'(out_a_last), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    chk("rst_out_b_valid", 64'(out_b_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_ovf", 64'(res_ovf), 64'd0);
    drive(8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table: basic tile, back-to-back tiles, valid gating, single-product tile
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].a, tbl[i].av, tbl[i].al, tbl[i].b, tbl[i].bv);
      tick();
      chk($sformatf("v%0d_out_a", i), 64'(out_a), 64'(tbl[i].a));
      chk($sformatf("v%0d_out_a_valid", i), 64'(out_a_valid), 64'(tbl[i].av));
      chk($sformatf("v%0d_out_a_last", i), 64'(out_a_last), 64'(tbl[i].al));
      chk($sformatf("v%0d_out_b", i), 64'(out_b), 64'(tbl[i].b));
      chk($sformatf("v%0d_out_b_valid", i), 64'(out_b_valid), 64'(tbl[i].bv));
      chk($sformatf("v%0d_res_valid", i), 64'(res_valid), 64'(tbl[i].rv));
      chk($sformatf("v%0d_res", i), 64'(res), 64'(tbl[i].r));
      chk($sformatf("v%0d_res_ovf", i), 64'(res_ovf), 64'(tbl[i].ovf));
    end

    // Saturation / wrap at 16 bits: 3 x 127*127 = 48387
    do_reset();
    drive(8'd127, 1'b1, 1'b0, 8'd127, 1'b1); tick();
    drive(8'd127, 1'b1, 1'b0, 8'd127, 1'b1); tick();
    drive(8'd127, 1'b1, 1'b1, 8'd127, 1'b1); tick();
    chk("sat_no_early_pulse", 64'(s_rv), 64'd0);
    drive(8'd0, 1'b0, 1'b0, 8'd0, 1'b0); tick();
    chk("sat16_res", 64'(s_res), 64'h7FFF);
    chk("sat16_ovf", 64'(s_ovf), 64'd1);
    chk("sat16_rv", 64'(s_rv), 64'd1);
    chk("wrap16_res", 64'(w_res), 64'hBD03);
    chk("wrap16_ovf", 64'(w_ovf), 64'd1);
    chk("wrap16_rv", 64'(w_rv), 64'd1);
    chk("acc32_res", 64'(res), 64'd48387);
    chk("acc32_ovf", 64'(res_ovf), 64'd0);
    chk("uns_3x127_res", 64'(u_res), 64'd48387);

    // Unsigned 255*255; signed instances see (-1)*(-1) and must clear the overflow flag
    drive(8'd255, 1'b1, 1'b1, 8'd255, 1'b1); tick();
    drive(8'd0, 1'b0, 1'b0, 8'd0, 1'b0); tick();
    chk("uns_res", 64'(u_res), 64'd65025);
    chk("uns_ovf", 64'(u_ovf), 64'd0);
    chk("uns_rv", 64'(u_rv), 64'd1);
    chk("sat16_next_res", 64'(s_res), 64'd1);
    chk("sat16_next_ovf", 64'(s_ovf), 64'd0);
    chk("dut_neg1sq_res", 64'(res), 64'd1);

    // Stall mid-tile
    drive(8'd2, 1'b1, 1'b0, 8'd3, 1'b1); tick();
    drive(8'd2, 1'b1, 1'b0, 8'd3, 1'b1); tick();
    en = 1'b0;
    drive(8'd5, 1'b1, 1'b1, 8'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_out_a", k), 64'(out_a), 64'd2);
      chk($sformatf("stall%0d_out_b", k), 64'(out_b), 64'd3);
      chk($sformatf("stall%0d_out_a_last", k), 64'(out_a_last), 64'd0);
      chk($sformatf("stall%0d_res", k), 64'(res), 64'd1);
      chk($sformatf("stall%0d_res_valid", k), 64'(res_valid), 64'd0);
    end

    // Asynchronous reset between edges discards the partial sum
    rst_n = 1'b0;
    #2;
    chk("arst_out_a", 64'(out_a), 64'd0);
    chk("arst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("arst_out_b", 64'(out_b), 64'd0);
    chk("arst_res", 64'(res), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_ovf", 64'(res_ovf), 64'd0);
    en = 1'b1;
    drive(8'd4, 1'b1, 1'b1, 8'd4, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rv0", 64'(res_valid), 64'd0);
    chk("post_rst_out_a", 64'(out_a), 64'd4);
    drive(8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    chk("post_rst_res", 64'(res), 64'd16);
    chk("post_rst_rv1", 64'(res_valid), 64'd1);
    tick();
    chk("post_rst_pulse_end", 64'(res_valid), 64'd0);
    chk("post_rst_res_hold", 64'(res), 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
